// File: rtl/ppu_byte_tx.sv
// ppu_byte_tx -- transmit end of the PPU byte-input strobe/ack link.
//
// Bytes written by the upstream source are queued in a DEPTH-entry FIFO and
// presented one at a time on data_o/stb_o. The receiver acknowledges with a
// level ack_o. A full four-phase handshake is used: stb_o rises, ack_o rises,
// stb_o falls, ack_o falls. A byte counter tracks the position in the line
// (h_count) and frame (v_count). A one-cycle sync pulse precedes byte 0 of
// every frame, and frame_done pulses when the last byte of a frame is taken.
//
// Optional build macro: PPU_TX_TIMEOUT_EN
//   When defined, a strobe that is not acknowledged within TIMEOUT cycles is
//   withdrawn, the sticky err flag is set, and the same byte is re-presented
//   later. When undefined, the FSM waits for ack_o indefinitely and err is 0.
module ppu_byte_tx #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4,
    parameter int LINE_LEN  = 32,
    parameter int LINES     = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic [ADDR_BITS:0]   level,
    output logic                 sync,
    output logic [7:0]           data_o,
    output logic                 stb_o,
    input  logic                 ack_o,
    output logic                 frame_done,
    output logic                 err
);

    localparam int HW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int VW = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [ADDR_BITS:0] DEPTH_L = DEPTH[ADDR_BITS:0];
    localparam logic [HW-1:0]      H_LAST  = HW'(LINE_LEN - 1);
    localparam logic [VW-1:0]      V_LAST  = VW'(LINES - 1);

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH != (1 << ADDR_BITS) || TIMEOUT < 1) begin : g_cfg_check
        $error("ppu_byte_tx: DEPTH must equal 2**ADDR_BITS and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        STROBE,
        RELEASE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [HW-1:0]        h_count;
    logic [VW-1:0]        v_count;

    logic push;
    logic pop;
    logic enter_strobe;
    logic timeout_hit;

    // full comes from the registered level, so a same-cycle pop never
    // makes room for a write.
    assign full = (level == DEPTH_L);
    assign push = wr_en && !full;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef PPU_TX_TIMEOUT_EN
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wait_cnt;

    // Cycles spent in STROBE without an acknowledge; restarts on each entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (enter_strobe) begin
            wait_cnt <= '0;
        end else if (state == STROBE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // An acknowledge in the final cycle still wins over the timeout.
    assign timeout_hit = (state == STROBE) && !ack_o && (wait_cnt == WAIT_LAST);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the pop/load strobes derived from it.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        enter_strobe = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    if (h_count == '0 && v_count == '0) begin
                        state_nxt = SYNC;
                    end else begin
                        state_nxt    = STROBE;
                        enter_strobe = 1'b1;
                    end
                end
            end
            SYNC: begin
                // Level cannot drop here: pops only happen in STROBE.
                state_nxt    = STROBE;
                enter_strobe = 1'b1;
            end
            STROBE: begin
                if (ack_o) begin
                    pop       = 1'b1;
                    state_nxt = RELEASE;
                end else if (timeout_hit) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // Waiting for ack_o low guarantees one byte per acknowledge.
                if (!ack_o) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered link outputs: strobe and sync follow the next state, data
    // is captured from the FIFO head on entry to STROBE and held there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_o  <= 1'b0;
            sync   <= 1'b0;
            data_o <= '0;
        end else begin
            stb_o <= (state_nxt == STROBE);
            sync  <= (state_nxt == SYNC);
            if (enter_strobe) begin
                data_o <= mem[rd_ptr];
            end
        end
    end

    // Line/frame position; advances only on an accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count    <= '0;
            v_count    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pop) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    if (v_count == V_LAST) begin
                        v_count    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        v_count <= v_count + 1'b1;
                    end
                end else begin
                    h_count <= h_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_byte_tx.sv
// Testbench for ppu_byte_tx: table-driven byte ordering/sync checks plus
// hand-written sequences for backpressure, frame wrap, reset and ack corners.
module tb_ppu_byte_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic [4:0] level;
    logic       sync;
    logic [7:0] data_o;
    logic       stb_o;
    logic       ack_o;
    logic       frame_done;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;

    int         sync_cnt = 0;
    int         fd_cnt   = 0;
    int         stb_cyc  = 0;
    logic [7:0] last_stb_data = 8'h00;
    int         sync_mark = 0;

    ppu_byte_tx #(
        .DEPTH(16),
        .ADDR_BITS(4),
        .LINE_LEN(32),
        .LINES(32),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .level(level),
        .sync(sync),
        .data_o(data_o),
        .stb_o(stb_o),
        .ack_o(ack_o),
        .frame_done(frame_done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters: values seen just before each rising edge.
    always @(posedge clk) begin
        if (sync) sync_cnt++;
        if (frame_done) fd_cnt++;
        if (stb_o) begin
            stb_cyc++;
            last_stb_data = data_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        ack_o = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sync_mark = sync_cnt;
    endtask

    // Receiver: wait for a strobe, ack one cycle later, release after stb drops.
    task automatic recv(output logic [7:0] d, output int ns, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        d  = 8'h00;
        ns = 0;
        while (!stb_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!stb_o) begin
            ok = 1'b0;
            return;
        end
        d  = data_o;
        ns = sync_cnt - sync_mark;
        ack_o = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stb_o && n < 300);
        if (stb_o) ok = 1'b0;
        ack_o = 1'b0;
        @(negedge clk);
        sync_mark = sync_cnt;
    endtask

    typedef struct {
        logic [7:0] wr;
        logic [7:0] exp_data;
        int         exp_sync;
    } vec_t;

    vec_t tbl [3];

    initial begin
        logic [7:0] d;
        int         ns;
        bit         ok;
        int         base;
        int         fd0;
        int         bad_data;
        int         bad_sync;
        int         n;

        tbl[0] = '{wr: 8'hA1, exp_data: 8'hA1, exp_sync: 1};
        tbl[1] = '{wr: 8'hB2, exp_data: 8'hB2, exp_sync: 0};
        tbl[2] = '{wr: 8'hC3, exp_data: 8'hC3, exp_sync: 0};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ack_o   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_stb", {31'd0, stb_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_sync", {31'd0, sync}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        rst_n = 1'b1;
        sync_mark = sync_cnt;

        // Test 1: three bytes, sync only before the first
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = tbl[i].wr;
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("t1_latency_stb", {31'd0, stb_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            recv(d, ns, ok);
            chk($sformatf("t1_ok[%0d]", i), {31'd0, ok}, 32'd1);
            chk($sformatf("t1_data[%0d]", i), {24'd0, d}, {24'd0, tbl[i].exp_data});
            chk($sformatf("t1_sync[%0d]", i), ns, tbl[i].exp_sync);
        end
        chk("t1_level_end", {27'd0, level}, 32'd0);
        chk("t1_stb_end", {31'd0, stb_o}, 32'd0);

        // Test 2: overflow with ack held low, mid-frame (no sync expected)
        base = sync_cnt;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 1) chk("t2_stb_before", {31'd0, stb_o}, 32'd0);
            if (i == 2) chk("t2_latency2_stb", {31'd0, stb_o}, 32'd1);
            wr_en   = 1'b1;
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_level", {27'd0, level}, 32'd16);
        bad_data = 0;
        for (int i = 0; i < 16; i++) begin
            recv(d, ns, ok);
            if (!ok || d !== 8'(i)) bad_data++;
        end
        chk("t2_bad_bytes", bad_data, 0);
        repeat (6) @(negedge clk);
        chk("t2_dropped_stb", {31'd0, stb_o}, 32'd0);
        chk("t2_level_end", {27'd0, level}, 32'd0);
        chk("t2_no_sync", sync_cnt - base, 0);

        // Test 3: 1025 bytes, one full frame plus one
        do_reset();
        fd0 = fd_cnt;
        bad_data = 0;
        bad_sync = 0;
        fork
            begin
                int k;
                int guard;
                k = 0;
                guard = 0;
                while (k < 1025 && guard < 20000) begin
                    @(negedge clk);
                    guard++;
                    if (!full) begin
                        wr_en   = 1'b1;
                        wr_data = 8'(k);
                        k++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge clk);
                wr_en = 1'b0;
            end
            begin
                for (int i = 0; i < 1025; i++) begin
                    recv(d, ns, ok);
                    if (!ok || d !== 8'(i)) bad_data++;
                    if (i == 0) chk("t3_sync_first", ns, 1);
                    else if (i == 1024) chk("t3_sync_second_frame", ns, 1);
                    else if (ns != 0) bad_sync++;
                    if (i == 1022) chk("t3_frame_done_early", fd_cnt - fd0, 0);
                    if (i == 1023) chk("t3_frame_done_at_1024", fd_cnt - fd0, 1);
                end
            end
        join
        chk("t3_bad_bytes", bad_data, 0);
        chk("t3_stray_sync", bad_sync, 0);
        chk("t3_frame_done_total", fd_cnt - fd0, 1);

        // Test 4: asynchronous reset while a byte is strobed
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'h30 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("t4_pre_stb", {31'd0, stb_o}, 32'd1);
        chk("t4_pre_level", {27'd0, level}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_async_stb", {31'd0, stb_o}, 32'd0);
        chk("t4_async_data", {24'd0, data_o}, 32'd0);
        chk("t4_async_level", {27'd0, level}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sync_mark = sync_cnt;
        base = stb_cyc;
        repeat (10) @(negedge clk);
        chk("t4_no_stb_after", stb_cyc - base, 0);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        wr_en = 1'b0;
        recv(d, ns, ok);
        chk("t4_new_byte", {23'd0, ok, d}, {23'd0, 1'b1, 8'h77});

        // Test 5: ack held high accepts exactly one byte
        do_reset();
        ack_o = 1'b1;
        base = stb_cyc;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_one_strobe", stb_cyc - base, 1);
        chk("t5_first_data", {24'd0, last_stb_data}, 32'h11);
        chk("t5_parked_stb", {31'd0, stb_o}, 32'd0);
        chk("t5_level", {27'd0, level}, 32'd1);
        ack_o = 1'b0;
        recv(d, ns, ok);
        chk("t5_second", {23'd0, ok, d}, {23'd0, 1'b1, 8'h22});

`ifdef PPU_TX_TIMEOUT_EN
        // Test 6: ack timeout, byte kept and re-presented
        do_reset();
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        while (!stb_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (stb_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_stb_cycles", n, 8);
        chk("t6_err", {31'd0, err}, 32'd1);
        chk("t6_level_kept", {27'd0, level}, 32'd1);
        recv(d, ns, ok);
        chk("t6_represent", {23'd0, ok, d}, {23'd0, 1'b1, 8'h5A});
        chk("t6_level_popped", {27'd0, level}, 32'd0);
        chk("t6_err_sticky", {31'd0, err}, 32'd1);
`else
        n = 0;
`endif

        do_reset();
        chk("final_err_cleared", {31'd0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
